// File: rtl/sram_obi_pkg.sv
// Shared types and window defaults for the sram_d OBI arbiter and its response FIFO.
package sram_obi_pkg;

    localparam logic [31:0] DEF_SRAM_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_SRAM_END_ADDR  = 32'h8000_C000;

    typedef logic [1:0] mst_id_t;

    typedef struct packed {
        mst_id_t id;
        logic    err;
    } rsp_entry_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

endpackage

// File: rtl/obi_rsp_fifo.sv
// In-flight response FIFO: records which master owns each accepted request and
// whether the arbiter answers it locally with an error.
module obi_rsp_fifo
    import sram_obi_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push,
    input  rsp_entry_t wdata,
    input  logic       pop,
    output rsp_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/sram_d_obi_arbiter.sv
// Round-robin arbiter of N OBI data masters onto the sram_d port; out-of-window
// requests are answered locally with an error, responses return in request order.
module sram_d_obi_arbiter
    import sram_obi_pkg::*;
#(
    parameter int          NUM_MASTERS     = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] SRAM_BASE_ADDR  = DEF_SRAM_BASE_ADDR,
    parameter logic [31:0] SRAM_END_ADDR   = DEF_SRAM_END_ADDR
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*4-1:0]  m_be_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]    m_rvalid_o,
    output logic [NUM_MASTERS*32-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic                      sram_req_o,
    input  logic                      sram_gnt_i,
    output logic [31:0]               sram_addr_o,
    output logic                      sram_we_o,
    output logic [3:0]                sram_be_o,
    output logic [31:0]               sram_wdata_o,
    input  logic                      sram_rvalid_i,
    input  logic [31:0]               sram_rdata_i,
    output logic                      illegal_access_o,
    output logic [15:0]               illegal_count_o
);

    logic [NUM_MASTERS-1:0][31:0] addr_a;
    logic [NUM_MASTERS-1:0][31:0] wdata_a;
    logic [NUM_MASTERS-1:0][31:0] rdata_a;
    logic [NUM_MASTERS-1:0][3:0]  be_a;

    assign addr_a    = m_addr_i;
    assign wdata_a   = m_wdata_i;
    assign be_a      = m_be_i;
    assign m_rdata_o = rdata_a;

    mst_id_t                    ptr;
    mst_id_t                    win;
    mst_id_t                    off;
    logic [2:0]                 win_sum;
    logic                       any_req;
    logic [2*NUM_MASTERS-1:0]   req_dbl;
    logic [NUM_MASTERS-1:0]     req_rot;
    logic [NUM_MASTERS-1:0]     win_oh;
    obi_req_t                   win_req;
    logic                       legal;
    logic                       gnt_en;
    logic                       accept;

    rsp_entry_t                 head;
    logic                       full;
    logic                       empty;
    logic                       rsp_vld;
    logic [NUM_MASTERS-1:0]     rsp_oh;

    // Rotate the request vector so index 0 is the pointer, pick the first set bit.
    always_comb begin
        req_dbl = {m_req_i, m_req_i} >> ptr;
        req_rot = req_dbl[NUM_MASTERS-1:0];
        off     = '0;
        any_req = 1'b0;
        for (int i = NUM_MASTERS-1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off     = mst_id_t'(i);
                any_req = 1'b1;
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, off};
        win     = (win_sum >= 3'(NUM_MASTERS)) ? mst_id_t'(win_sum - 3'(NUM_MASTERS))
                                               : mst_id_t'(win_sum);
    end

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_win
        assign win_oh[k] = any_req && (win == mst_id_t'(k));
    end

    always_comb begin
        win_req = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (win_oh[k]) begin
                win_req = '{addr: addr_a[k], we: m_we_i[k], be: be_a[k], wdata: wdata_a[k]};
            end
        end
    end

    assign legal = (win_req.addr >= SRAM_BASE_ADDR) && (win_req.addr < SRAM_END_ADDR);

    // Reset gates the combinational request path so nothing leaks out while held in reset.
    assign gnt_en           = rst_ni && any_req && !full;
    assign sram_req_o       = gnt_en && legal;
    assign accept           = gnt_en && (legal ? sram_gnt_i : 1'b1);
    assign m_gnt_o          = win_oh & {NUM_MASTERS{accept}};
    assign illegal_access_o = accept && !legal;

    assign sram_addr_o  = win_req.addr;
    assign sram_we_o    = win_req.we;
    assign sram_be_o    = win_req.be;
    assign sram_wdata_o = win_req.wdata;

    obi_rsp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (accept),
        .wdata  ('{id: win, err: !legal}),
        .pop    (rsp_vld),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    // Error entries retire on their own; SRAM entries wait for rvalid. Stray rvalid with
    // an empty FIFO (e.g. in flight across a reset) is dropped here.
    assign rsp_vld = !empty && (head.err || sram_rvalid_i);

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_rsp
        assign rsp_oh[k]     = rsp_vld && (head.id == mst_id_t'(k));
        assign m_rvalid_o[k] = rsp_oh[k];
        assign m_err_o[k]    = rsp_oh[k] && head.err;
        assign rdata_a[k]    = (rsp_oh[k] && !head.err) ? sram_rdata_i : 32'h0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr             <= '0;
            illegal_count_o <= '0;
        end else begin
            if (accept) ptr <= (win == mst_id_t'(NUM_MASTERS-1)) ? '0 : win + 2'd1;
            if (illegal_access_o && illegal_count_o != 16'hFFFF)
                illegal_count_o <= illegal_count_o + 16'd1;
        end
    end

endmodule
